// File: rtl/cbs_pkg.sv
// Shared constants and state encoding for the CBS ingress path.
package cbs_pkg;

  localparam logic [15:0] TPID_CTAG       = 16'h8100;
  localparam logic [15:0] TPID_STAG       = 16'h88A8;
  localparam int          HDR_LEN         = 15;
  localparam logic [15:0] PCP_MAP_DEFAULT = 16'hFA50;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_DRAIN = 2'd1,
    S_PASS  = 2'd2
  } state_t;

endpackage

// File: rtl/pcp_hdr_buf.sv
// Header holding buffer: one write port, one asynchronous read port.
module pcp_hdr_buf #(
  parameter int DEPTH = 15,
  parameter int WIDTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are not reset; the top's byte count decides what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcp_classifier.sv
// Buffers the 15-byte Ethernet header, maps the 802.1Q PCP to a class code on tdest.
// Optional: define PCP_CLASSIFIER_STAG_EN to also classify 802.1ad (88A8) tagged frames.
module pcp_classifier
  import cbs_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int C_AXIS_TDEST_WIDTH = 2,
  parameter logic [8*C_AXIS_TDEST_WIDTH-1:0] PCP_MAP = PCP_MAP_DEFAULT,
  parameter logic [C_AXIS_TDEST_WIDTH-1:0]   DEFAULT_DEST = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [C_AXIS_TDEST_WIDTH-1:0] m_axis_tdest
);

  localparam int         BW       = C_AXIS_TDATA_WIDTH + C_AXIS_TKEEP_WIDTH + 1;
  localparam logic [3:0] LAST_HDR = 4'(HDR_LEN - 1);

  state_t                        state, state_nxt;
  logic [3:0]                    cnt, rd;
  logic                          frame_ended;
  logic [C_AXIS_TDEST_WIDTH-1:0] dest, class_dest;
  logic [15:0]                   tpid;
  logic                          tpid_hit;
  logic [2:0]                    pcp;
  logic [BW-1:0]                 rd_word;
  logic                          hdr_acc, hdr_done, drain_done, pass_last;

  pcp_hdr_buf #(
    .DEPTH (HDR_LEN),
    .WIDTH (BW),
    .AW    (4)
  ) u_hdr_buf (
    .clk   (clk),
    .we    (hdr_acc),
    .waddr (cnt),
    .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .raddr (rd),
    .rdata (rd_word)
  );

  assign hdr_acc    = (state == S_HDR) && !rst && s_axis_tvalid;
  assign hdr_done   = hdr_acc && (s_axis_tlast || (cnt == LAST_HDR));
  assign drain_done = (state == S_DRAIN) && m_axis_tready && (rd == cnt - 4'd1);
  assign pass_last  = (state == S_PASS) && s_axis_tvalid && m_axis_tready && s_axis_tlast;

`ifdef PCP_CLASSIFIER_STAG_EN
  assign tpid_hit = (tpid == TPID_CTAG) || (tpid == TPID_STAG);
`else
  assign tpid_hit = (tpid == TPID_CTAG);
`endif

  // The TCI high byte is classified as it arrives, so the buffer needs no second read port.
  assign pcp        = s_axis_tdata[7:5];
  assign class_dest = ((cnt == LAST_HDR) && tpid_hit)
                      ? PCP_MAP[int'(pcp)*C_AXIS_TDEST_WIDTH +: C_AXIS_TDEST_WIDTH]
                      : DEFAULT_DEST;
  assign m_axis_tdest = dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HDR;
      cnt         <= '0;
      rd          <= '0;
      frame_ended <= 1'b0;
      dest        <= DEFAULT_DEST;
      tpid        <= '0;
    end else begin
      state <= state_nxt;
      if (hdr_acc) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd12 || cnt == 4'd13) tpid <= {tpid[7:0], s_axis_tdata[7:0]};
        if (hdr_done) begin
          frame_ended <= s_axis_tlast;
          dest        <= class_dest;
        end
      end
      if (state == S_DRAIN && m_axis_tready) begin
        rd <= rd + 4'd1;
        if (drain_done) begin
          rd <= '0;
          if (frame_ended) begin
            cnt         <= '0;
            frame_ended <= 1'b0;
          end
        end
      end
      if (pass_last) begin
        cnt <= '0;
        rd  <= '0;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = rd_word[C_AXIS_TDATA_WIDTH-1:0];
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      S_HDR: begin
        s_axis_tready = 1'b1;
        if (hdr_done) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = rd_word[BW-2 -: C_AXIS_TKEEP_WIDTH];
        m_axis_tlast  = rd_word[BW-1];
        if (drain_done) state_nxt = frame_ended ? S_HDR : S_PASS;
      end
      S_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (pass_last) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
    if (rst) s_axis_tready = 1'b0;
  end

endmodule

// File: tb/tb_pcp_classifier.sv
// Self-checking bench for pcp_classifier: table vectors, hand sequences, random frames.
module tb_pcp_classifier;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic [1:0] dest;
  } beat_t;

  typedef struct {
    int          len;
    logic [15:0] tpid;
    logic [7:0]  tci;
    int          mode;
    int          gap;
    logic [1:0]  dest;
  } vec_t;

`ifdef PCP_CLASSIFIER_STAG_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif
  localparam logic [1:0] STAG_PCP6_DEST = STAG ? 2'd3 : 2'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic [0:0] s_axis_tkeep;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic [0:0] m_axis_tkeep;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic [1:0] m_axis_tdest;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    ready_mode = 0;

  pcp_classifier dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdest  (m_axis_tdest)
  );

  always #5 clk = ~clk;

  // Egress ready pattern: 0 always ready, 1 toggling, 2 random, 3 held by the main sequence.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ~m_axis_tready;
        2: m_axis_tready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Egress monitor: every transferred beat must match the scoreboard; stalled beats must hold.
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || got !== prev_beat) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                   m_axis_tvalid, got, prev_beat);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: got data=%h keep=%b last=%b dest=%0d, required no beat",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("[TB] FAIL beat: got data=%h keep=%b last=%b dest=%0d, required data=%h keep=%b last=%b dest=%0d",
                     got.data, got.keep, got.last, got.dest, e.data, e.keep, e.last, e.dest);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = got;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Reference classification from the frame bytes alone.
  function automatic logic [1:0] model_dest(input byte_q_t f);
    logic [15:0] map;
    logic [15:0] tp;
    int          p;
    map = 16'hFA50;
    if (f.size() < 15) return 2'd0;
    tp = {f[12], f[13]};
    if (!(tp == 16'h8100 || (STAG && tp == 16'h88A8))) return 2'd0;
    p = int'(f[14]) / 32;
    return 2'((map >> (2 * p)) & 16'h3);
  endfunction

  function automatic byte_q_t make_frame(input int len, input logic [15:0] tpid, input logic [7:0] tci);
    byte_q_t f;
    for (int i = 0; i < len; i++) begin
      if (i == 12)      f.push_back(tpid[15:8]);
      else if (i == 13) f.push_back(tpid[7:0]);
      else if (i == 14) f.push_back(tci);
      else              f.push_back(8'($urandom));
    end
    return f;
  endfunction

  // Sends the first nsend bytes of frame f; optionally queues the expected egress beats.
  task automatic applyStimulus(input byte_q_t f, input int nsend, input bit push_exp,
                               input logic [1:0] dest, input int gap_pct);
    logic k;
    bit   ok;
    int   waited;
    for (int i = 0; i < nsend; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      k = 1'($urandom);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = f[i];
      s_axis_tkeep  = k;
      s_axis_tlast  = (i == f.size() - 1);
      if (push_exp) exp_q.push_back(beat_t'{f[i], k, (i == f.size() - 1), dest});
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 2000) begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("[TB] FAIL ingress_timeout: got no tready for byte %0d after %0d cycles, required acceptance",
                 i, waited);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 8'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checkOutput({"drain_", name}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  vec_t    vecs[10];
  byte_q_t f;
  int      n, t;
  logic [15:0] tp;

  initial begin
    vecs[0] = '{64, 16'h8100, 8'hA0, 0, 0,  2'd2};
    vecs[1] = '{60, 16'h0800, 8'h45, 0, 0,  2'd0};
    vecs[2] = '{10, 16'h8100, 8'hE0, 0, 0,  2'd0};
    vecs[3] = '{40, 16'h8100, 8'hE0, 1, 0,  2'd3};
    vecs[4] = '{30, 16'h88A8, 8'hC0, 0, 0,  STAG_PCP6_DEST};
    vecs[5] = '{1,  16'h8100, 8'hE0, 0, 0,  2'd0};
    vecs[6] = '{15, 16'h8100, 8'h60, 0, 0,  2'd1};
    vecs[7] = '{14, 16'h8100, 8'hE0, 1, 0,  2'd0};
    vecs[8] = '{16, 16'h8100, 8'h40, 2, 10, 2'd1};
    vecs[9] = '{20, 16'h8100, 8'h80, 2, 30, 2'd2};

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tkeep  = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("reset_m_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("reset_m_tdest", 32'(m_axis_tdest), 32'd0);
    checkOutput("reset_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_s_tready", 32'(s_axis_tready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      ready_mode = vecs[i].mode;
      f = make_frame(vecs[i].len, vecs[i].tpid, vecs[i].tci);
      applyStimulus(f, f.size(), 1'b1, vecs[i].dest, vecs[i].gap);
    end
    wait_drain("table");

    $display("[TB] header latency and stalled drain");
    ready_mode = 3;
    m_axis_tready = 1'b0;
    f = make_frame(20, 16'h8100, 8'hE0);
    n = 0;
    t = 0;
    fork
      applyStimulus(f, 20, 1'b1, 2'd3, 0);
      begin
        while (n < 15 && t < 300) begin
          @(negedge clk);
          if (s_axis_tvalid && s_axis_tready) n++;
          t++;
        end
        checkOutput("hdr_accept_count", 32'(n), 32'd15);
        checkOutput("hdr_no_valid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        checkOutput("first_beat_valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("first_beat_data", 32'(m_axis_tdata), 32'(f[0]));
        checkOutput("first_beat_dest", 32'(m_axis_tdest), 32'd3);
        checkOutput("drain_s_tready", 32'(s_axis_tready), 32'd0);
        repeat (4) @(negedge clk);
        ready_mode = 1;
      end
    join
    wait_drain("stall");

    $display("[TB] reset during header replay");
    ready_mode = 3;
    m_axis_tready = 1'b0;
    f = make_frame(30, 16'h8100, 8'hA0);
    applyStimulus(f, 15, 1'b0, 2'd2, 0);
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(m_axis_tvalid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("midreset_s_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("midreset_m_tdest", 32'(m_axis_tdest), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    f = make_frame(20, 16'h8100, 8'h60);
    applyStimulus(f, 20, 1'b1, 2'd1, 0);
    wait_drain("after_reset");

    $display("[TB] random frames");
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       tp = 16'h8100;
        1:       tp = 16'h88A8;
        2:       tp = 16'h0800;
        default: tp = 16'($urandom);
      endcase
      f = make_frame(int'($urandom_range(1, 70)), tp, 8'($urandom));
      ready_mode = int'($urandom_range(0, 2));
      applyStimulus(f, f.size(), 1'b1, model_dest(f), int'($urandom_range(0, 30)));
    end
    wait_drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
